// File: rtl/arm.sv
// Pipelined ARM core top, instruction-fetch milestone: PC, built-in ROM and stage registers.
// Optional trace stages (ID/EXE, EXE/MEM, MEM/WB PC fields) are built when ARM_PIPE_TRACE_EN is defined.
module arm (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
`ifdef ARM_PIPE_TRACE_EN
  ,
  output logic [31:0] exe_pc,
  output logic [31:0] mem_pc,
  output logic [31:0] wb_pc
`endif
);

  // Hazard/branch controls are not produced yet; tied off until execute exists.
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  assign freeze       = 1'b0;
  assign branch_taken = 1'b0;
  assign branch_addr  = 32'h0000_0000;

  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] id_pc_reg;
  logic [31:0] id_instr_reg;

  assign pc_plus4 = pc_reg + 32'd4;
  assign pc_next  = freeze ? pc_reg : (branch_taken ? branch_addr : pc_plus4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Fixed program: word k is MOV R0,#k; index uses PC[7:2] so fetch wraps every 256 bytes.
  logic [31:0] rom [64];
  for (genvar gi = 0; gi < 64; gi++) begin : g_rom
    assign rom[gi] = 32'hE3A0_0000 | 32'(gi);
  end

  assign if_pc    = pc_reg;
  assign if_instr = rom[pc_reg[7:2]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_reg    <= '0;
      id_instr_reg <= '0;
    end else if (!freeze) begin
      id_pc_reg    <= pc_plus4;
      id_instr_reg <= if_instr;
    end
  end

  assign id_pc    = id_pc_reg;
  assign id_instr = id_instr_reg;

`ifdef ARM_PIPE_TRACE_EN
  // Only the PC travels past ID for now; instruction fields join once decode consumes them.
  logic [31:0] exe_pc_reg;
  logic [31:0] mem_pc_reg;
  logic [31:0] wb_pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_pc_reg <= '0;
      mem_pc_reg <= '0;
      wb_pc_reg  <= '0;
    end else if (!freeze) begin
      exe_pc_reg <= id_pc_reg;
      mem_pc_reg <= exe_pc_reg;
      wb_pc_reg  <= mem_pc_reg;
    end
  end

  assign exe_pc = exe_pc_reg;
  assign mem_pc = mem_pc_reg;
  assign wb_pc  = wb_pc_reg;
`endif

endmodule

// File: tb/tb_arm.sv
// Directed self-checking bench for arm: reset, fetch sequence, ROM wrap, async reset, PC wrap.
module tb_arm;
  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef ARM_PIPE_TRACE_EN
  logic [31:0] exe_pc;
  logic [31:0] mem_pc;
  logic [31:0] wb_pc;
`endif

  int tests;
  int fails;

  arm dut (
    .clk      (clk),
    .rst      (rst),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .id_pc    (id_pc),
    .id_instr (id_instr)
`ifdef ARM_PIPE_TRACE_EN
    ,
    .exe_pc   (exe_pc),
    .mem_pc   (mem_pc),
    .wb_pc    (wb_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stage k (0=ID,1=EXE,2=MEM,3=WB) after e edges from reset release holds 4*(e-k), else 0.
  function automatic logic [31:0] stage_pc(input int e, input int k);
    return (e > k) ? 32'(4 * (e - k)) : 32'h0;
  endfunction

  task automatic check_run(input int e);
    check("if_pc", if_pc, 32'(4 * e));
    check("if_instr", if_instr, 32'hE3A0_0000 | 32'(e % 64));
    check("id_pc", id_pc, stage_pc(e, 0));
    check("id_instr", id_instr, (e > 0) ? (32'hE3A0_0000 | 32'((e - 1) % 64)) : 32'h0);
`ifdef ARM_PIPE_TRACE_EN
    check("exe_pc", exe_pc, stage_pc(e, 1));
    check("mem_pc", mem_pc, stage_pc(e, 2));
    check("wb_pc", wb_pc, stage_pc(e, 3));
`endif
    $display("[TB] edge %0d: if_pc=%08h if_instr=%08h id_pc=%08h id_instr=%08h",
             e, if_pc, if_instr, id_pc, id_instr);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_if_pc"}, if_pc, 32'h0);
    check({tag, "_if_instr"}, if_instr, 32'hE3A0_0000);
    check({tag, "_id_pc"}, id_pc, 32'h0);
    check({tag, "_id_instr"}, id_instr, 32'h0);
`ifdef ARM_PIPE_TRACE_EN
    check({tag, "_exe_pc"}, exe_pc, 32'h0);
    check({tag, "_mem_pc"}, mem_pc, 32'h0);
    check({tag, "_wb_pc"}, wb_pc, 32'h0);
`endif
    $display("[TB] %s: if_pc=%08h id_pc=%08h", tag, if_pc, id_pc);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;

    // Reset held across three edges.
    #1;
    check_reset("rst_initial");
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset("rst_hold");
    end

    // Release and run to PC = 40; id_instr after edge 3 is E3A00002.
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_run(e);
    end
    check("pc40", if_pc, 32'd40);

    // Asynchronous reset between edges clears state immediately.
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    @(negedge clk);
    check_reset("rst_async_hold");
    rst = 1'b0;

    // Restart from PC 4, run 64 edges total for the ROM wrap.
    for (int e = 1; e <= 64; e++) begin
      step();
      if (e <= 5 || e >= 62) check_run(e);
    end
    check("wrap_if_pc", if_pc, 32'd256);
    check("wrap_if_instr", if_instr, 32'hE3A0_0000);
    check("wrap_id_instr", id_instr, 32'hE3A0_003F);

    // Load PC with FFFFFFFC through the next-PC path, then let the adder wrap it.
    force dut.pc_next = 32'hFFFF_FFFC;
    step();
    release dut.pc_next;
    #1;
    check("top_if_pc", if_pc, 32'hFFFF_FFFC);
    check("top_if_instr", if_instr, 32'hE3A0_003F);
    $display("[TB] forced: if_pc=%08h if_instr=%08h", if_pc, if_instr);
    step();
    check("pcwrap_if_pc", if_pc, 32'h0);
    check("pcwrap_if_instr", if_instr, 32'hE3A0_0000);
    check("pcwrap_id_pc", id_pc, 32'h0);
    check("pcwrap_id_instr", id_instr, 32'hE3A0_003F);
    $display("[TB] wrapped: if_pc=%08h id_pc=%08h id_instr=%08h", if_pc, id_pc, id_instr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
